// File: rtl/joy_serializer.sv
// Parallel-in/serial-out joystick board model: captures active-low buttons on joy_load, shifts MSB first on joy_clk.
// Latency: joy_data moves SYNC_STAGES+1 clk cycles after a joy_clk rise or a joy_load fall.
// Backpressure: none; the decoder paces the transfer and extra shifts beyond NBITS flag overrun.
module joy_serializer #(
    parameter int   NBITS       = 16,
    parameter logic FILL        = 1'b1,
    parameter int   SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NBITS-1:0] frame_in,
    input  logic             joy_clk,
    input  logic             joy_load,
    output logic             joy_data,
    output logic             frame_done,
    output logic [5:0]       bit_count,
    output logic             overrun
);

    localparam logic [5:0] NBITS_W = 6'(NBITS);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] load_sync;
    logic                   sclk_prev;
    logic [NBITS-1:0]       shift_reg;

    logic sclk_s;
    logic load_s;
    logic sclk_rise;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign load_s    = load_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;

    // Preset-to-one synchronizers: idle-high lines see no false edge or load after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '1;
            load_sync <= '1;
            sclk_prev <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], joy_clk};
            load_sync <= {load_sync[SYNC_STAGES-2:0], joy_load};
            sclk_prev <= sclk_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '1;
            bit_count  <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else if (!load_s) begin
            // Load wins over any shift edge; capture stays transparent while held low.
            shift_reg  <= frame_in;
            bit_count  <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else if (sclk_rise) begin
            shift_reg <= {shift_reg[NBITS-2:0], FILL};
            if (bit_count < NBITS_W) begin
                bit_count  <= bit_count + 6'd1;
                frame_done <= (bit_count == NBITS_W - 6'd1);
            end else begin
                frame_done <= 1'b0;
                overrun    <= 1'b1;
            end
        end else begin
            frame_done <= 1'b0;
        end
    end

    assign joy_data = shift_reg[NBITS-1];

endmodule

// File: tb/tb_joy_serializer.sv
// Directed bench for joy_serializer: loads, shifts, overrun, re-load, reset and held-load cases.
module tb_joy_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] frame_in = 16'hFFFF;
    logic        joy_clk = 1'b0;
    logic        joy_load = 1'b1;
    logic        joy_data;
    logic        frame_done;
    logic [5:0]  bit_count;
    logic        overrun;

    int errors = 0;
    int checks = 0;
    int fd_total = 0;
    int fd_base;

    joy_serializer #(.NBITS(16), .FILL(1'b1), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_in  (frame_in),
        .joy_clk   (joy_clk),
        .joy_load  (joy_load),
        .joy_data  (joy_data),
        .frame_done(frame_done),
        .bit_count (bit_count),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) fd_total++;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        joy_clk = 1'b1;
        cyc(8);
        joy_clk = 1'b0;
        cyc(8);
    endtask

    task automatic do_load(input logic [15:0] f);
        frame_in = f;
        joy_load = 1'b0;
        cyc(10);
        joy_load = 1'b1;
        cyc(4);
    endtask

    logic [15:0] pat;

    initial begin
        // Reset state
        cyc(3);
        check("rst_joy_data", 32'(joy_data), 32'd1);
        check("rst_bit_count", 32'(bit_count), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        cyc(4);

        // 1: shifts without a load
        fd_base = fd_total;
        repeat (5) pulse();
        check("t1_joy_data", 32'(joy_data), 32'd1);
        check("t1_bit_count", 32'(bit_count), 32'd5);
        check("t1_no_frame_done", 32'(fd_total - fd_base), 32'd0);
        check("t1_overrun", 32'(overrun), 32'd0);

        // 2: full frame A5C3
        pat = 16'hA5C3;
        do_load(pat);
        fd_base = fd_total;
        check("t2_bit_count_load", 32'(bit_count), 32'd0);
        for (int k = 0; k < 15; k++) begin
            check($sformatf("t2_bit%0d", k), 32'(joy_data), 32'(pat[15-k]));
            pulse();
        end
        check("t2_bit15", 32'(joy_data), 32'(pat[0]));
        joy_clk = 1'b1;
        cyc(2);
        check("t2_fd_not_yet", 32'(frame_done), 32'd0);
        cyc(1);
        check("t2_fd_at_3", 32'(frame_done), 32'd1);
        cyc(1);
        check("t2_fd_one_cycle", 32'(frame_done), 32'd0);
        cyc(6);
        joy_clk = 1'b0;
        cyc(8);
        check("t2_bit_count", 32'(bit_count), 32'd16);
        check("t2_fd_count", 32'(fd_total - fd_base), 32'd1);
        check("t2_overrun", 32'(overrun), 32'd0);

        // 3: two extra shifts -> overrun
        pulse();
        pulse();
        check("t3_joy_data_fill", 32'(joy_data), 32'd1);
        check("t3_overrun", 32'(overrun), 32'd1);
        check("t3_bit_count", 32'(bit_count), 32'd16);
        check("t3_fd_count", 32'(fd_total - fd_base), 32'd1);
        joy_load = 1'b0;
        cyc(4);
        check("t3_load_clears_overrun", 32'(overrun), 32'd0);
        check("t3_load_clears_count", 32'(bit_count), 32'd0);
        joy_load = 1'b1;
        cyc(4);

        // 4: re-load mid-frame discards the partial frame
        fd_base = fd_total;
        do_load(16'h0001);
        repeat (7) pulse();
        check("t4_partial_count", 32'(bit_count), 32'd7);
        frame_in = 16'hFFFE;
        joy_load = 1'b0;
        cyc(4);
        check("t4_reload_count", 32'(bit_count), 32'd0);
        check("t4_reload_data", 32'(joy_data), 32'd1);
        joy_load = 1'b1;
        cyc(4);
        repeat (15) pulse();
        check("t4_data_after15", 32'(joy_data), 32'd0);
        check("t4_no_fd_after15", 32'(fd_total - fd_base), 32'd0);
        pulse();
        check("t4_fd_after16", 32'(fd_total - fd_base), 32'd1);
        check("t4_data_after16", 32'(joy_data), 32'd1);

        // 5: reset mid-frame
        do_load(16'h0000);
        repeat (9) pulse();
        check("t5_data_before_rst", 32'(joy_data), 32'd0);
        check("t5_count_before_rst", 32'(bit_count), 32'd9);
        rst_n = 1'b0;
        #1;
        check("t5_rst_data", 32'(joy_data), 32'd1);
        check("t5_rst_count", 32'(bit_count), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        pulse();
        check("t5_data_no_load", 32'(joy_data), 32'd1);

        // 6: held load ignores joy_clk and tracks frame_in
        frame_in = 16'h0000;
        joy_load = 1'b0;
        cyc(4);
        check("t6_data_0000", 32'(joy_data), 32'd0);
        for (int k = 0; k < 4; k++) begin
            frame_in = (k % 2 == 0) ? 16'hFFFF : 16'h0000;
            joy_clk = 1'b1;
            cyc(3);
            check($sformatf("t6_follow%0d", k), 32'(joy_data), (k % 2 == 0) ? 32'd1 : 32'd0);
            cyc(5);
            joy_clk = 1'b0;
            cyc(8);
            check($sformatf("t6_count%0d", k), 32'(bit_count), 32'd0);
        end
        joy_load = 1'b1;
        cyc(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
